cacheline_adaptor: RTL
======================

Name: cacheline_adaptor

Overview:
- Memory-side responder for the cache's line-granular memory interface: `mem_addr`, a 256-bit line out on writeback, a 256-bit line in on fill.
- Accepts one whole-line read or write request from the cache.
- Converts it into a 4-beat, 64-bit burst transaction on the physical-memory port.
- Returns a single-cycle `resp_o` once the line is fully transferred. Sits between the cache and physical memory.

Parameters:
- `s_line`, 256, line width in bits.
- `s_burst`, 64, memory beat width in bits. `s_line/s_burst` must be a power of two (default 4 beats).
- `s_offset`, 5, byte-offset bits cleared on `address_o`.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `line_i`  in  256  line from cache for writeback.
- `line_o`  out  256  assembled fill line to cache.
- `address_i`  in  32  line address from cache.
- `read_i`  in  1  cache line-read request.
- `write_i`  in  1  cache line-write request.
- `resp_o`  out  1  transaction complete, one cycle.
- `burst_i`  in  64  read beat from memory.
- `burst_o`  out  64  write beat to memory.
- `address_o`  out  32  burst address to memory.
- `read_o`  out  1  memory burst read request.
- `write_o`  out  1  memory burst write request.
- `resp_i`  in  1  memory beat valid/accepted.

Behaviour:
- Reset (`rst`==0 at an edge):
  - state=IDLE; beat counter=0.
  - `resp_o`, `read_o`, `write_o` = 0.
  - `line_o`, `burst_o`, `address_o` = 0.
  - Reset mid-burst aborts immediately: no `resp_o`, requests drop the next cycle.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - `read_i`=1 → latch `address_i` with low `s_offset` bits zeroed; clear counter; go to RD_BURST.
  - Else `write_i`=1 → same latch; also latch `line_i` into the write buffer; go to WR_BURST.
  - Both asserted → read wins. `write_i` is ignored until a later IDLE cycle.
  - The request is accepted in the cycle it is sampled. Requests outside IDLE are ignored.
- RD_BURST:
  - `read_o`=1; `address_o`=latched address.
  - Each cycle with `resp_i`=1: `burst_i` is written into `line_o[64k+63:64k]` (k=counter), then the counter increments.
  - `resp_i` gaps are legal; the counter holds during a gap.
  - On the beat with k=last → go to DONE. `read_o` is 0 from the DONE cycle onward.
- WR_BURST:
  - `write_o`=1; `address_o`=latched address.
  - `burst_o` = write-buffer beat k, combinational from the counter.
  - `resp_i`=1 means beat k is accepted; the counter increments.
  - Last beat accepted → go to DONE.
- DONE: `resp_o`=1 for exactly one cycle; go to IDLE.
- Read latency: minimum 6 cycles from request sample to `resp_o`. That is 1 accept cycle, 4 beats, then `resp_o` the cycle after the last beat.
- `line_o` holds the last filled line until the next read's first beat. A write never modifies `line_o`.
- The cache must drop `read_i`/`write_i` in the cycle after `resp_o`. Any request still high in that IDLE cycle starts a new transaction.
- `resp_i` while IDLE or DONE is ignored.
- Counter width is log2(`s_line/s_burst`). It wraps to 0 on leaving a burst state.

Decomposition:
- Package `cacheline_adaptor_itf`:
  - state enum `adaptor_state_t` (IDLE, RD_BURST, WR_BURST, DONE);
  - localparam `num_beats` = `s_line/s_burst`;
  - beat counter width.
- No sub-module. Beat insert/extract is indexed part-select logic inline.

Test Plan:
- Read fill: `read_i`=1, `address_i`=0x0000_1234. Memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive `resp_i` cycles.
  → `address_o`=0x0000_1220; `read_o` high for exactly 4 cycles; `resp_o` one cycle after the last beat; `line_o`={0x4444...,0x3333...,0x2222...,0x1111...}.
- Writeback: `line_i` = beats A,B,C,D (low to high), `write_i`=1, `address_i`=0x8000_00E0.
  → `burst_o` = A,B,C,D on successive `resp_i` cycles; `write_o` drops after D; `resp_o` single cycle; `line_o` unchanged.
- Gapped read: `resp_i` pattern 1,0,0,1,1,0,1.
  → 4 beats captured in order; `resp_o` one cycle after the 7th pattern cycle; no duplicate or missing beat.
- Simultaneous `read_i`=`write_i`=1 in IDLE.
  → read burst runs; `write_o` stays 0 throughout; the write starts only after `resp_o` if `write_i` is still held.
- Reset mid-read: drive `rst`=0 after beat 2.
  → next cycle `read_o`=0, `resp_o`=0, state IDLE. A new read after reset completes normally with 4 fresh beats.
- Back-to-back: a write then a read issued in the IDLE cycle after the write's `resp_o`.
  → two independent `resp_o` pulses; the read's `address_o` reflects the second `address_i`.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_itf: shared state encoding and default geometry for the line-to-burst adaptor.
package cacheline_adaptor_itf;
  localparam int line_bits   = 256;
  localparam int burst_bits  = 64;
  localparam int offset_bits = 5;
  localparam int num_beats   = line_bits / burst_bits;
  localparam int cnt_bits    = (num_beats > 1) ? $clog2(num_beats) : 1;
  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} adaptor_state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one whole-line cache read/write into a multi-beat burst on the memory port.
module cacheline_adaptor
  import cacheline_adaptor_itf::*;
#(
  parameter int s_line   = line_bits,
  parameter int s_burst  = burst_bits,
  parameter int s_offset = offset_bits
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);
  localparam int nb = s_line / s_burst;
  localparam int cw = (nb > 1) ? $clog2(nb) : 1;
  adaptor_state_t r_state, w_next;
  logic [cw-1:0]     r_cnt;
  logic [31:0]       r_addr;
  logic [s_line-1:0] r_wbuf, r_line;
  logic              w_last, w_accept, w_beat;
  assign w_last   = r_cnt == cw'(nb - 1);
  assign w_accept = r_state == IDLE && (read_i || write_i);
  assign w_beat   = (r_state == RD_BURST || r_state == WR_BURST) && resp_i;
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end
  // read has priority over write when both arrive in the same IDLE cycle
  always_comb begin
    w_next = r_state == IDLE ? (read_i ? RD_BURST : write_i ? WR_BURST : IDLE)
           : r_state == DONE ? IDLE
           : (resp_i && w_last) ? DONE : r_state;
  end
  always_comb begin
    read_o    = r_state == RD_BURST;
    write_o   = r_state == WR_BURST;
    resp_o    = r_state == DONE;
    address_o = r_addr;
    burst_o   = r_wbuf[int'(r_cnt)*s_burst +: s_burst];
    line_o    = r_line;
  end
  // the counter wraps to zero on the final beat, so leaving a burst needs no extra clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_addr <= '0;
      r_wbuf <= '0;
      r_line <= '0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_addr <= address_i & ~((32'd1 << s_offset) - 32'd1);
      if (!read_i) r_wbuf <= line_i;
    end else if (w_beat) begin
      r_cnt <= r_cnt + cw'(1);
      if (r_state == RD_BURST) r_line[int'(r_cnt)*s_burst +: s_burst] <= burst_i;
    end
  end
endmodule
